alu_share_arbiter: RTL

Two-requester arbiter and sequencer for one shared combinational ALU. Each requester presents an ALUOp/Funct pair and two operands using a valid/ready handshake. The block picks one requester, decodes the ALUOp/Funct pair into the 4-bit ALU operation code, drives the ALU from registered operands, captures the result, and returns it with a requester ID on a valid/ready response channel. It sits between the decode/issue stages and the ALU in the multi-issue datapath.

---
 rtl/alu_share_arbiter.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: arbitrates two requesters onto one shared combinational ALU.
// Decodes ALUOp/Funct into the ALU operation code, registers the operands,
// captures the ALU result after one settle cycle and returns it with the
// requester id on a valid/ready response channel.
// Optional build macro: ALU_ARB_FIXED_PRIO_EN (requester 0 always wins a tie);
// when undefined, ties are resolved round-robin.
module alu_share_arbiter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_aluop,
  input  logic [3:0]       req0_funct,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_aluop,
  input  logic [3:0]       req1_funct,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_operation,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_illegal
);

  localparam int unsigned OP_W = 4;
  localparam logic [OP_W-1:0] OP_AND = 4'b0000;
  localparam logic [OP_W-1:0] OP_OR  = 4'b0001;
  localparam logic [OP_W-1:0] OP_ADD = 4'b0010;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic gnt0;
  logic gnt1;
  logic load;
  logic load_id;
  logic capture;
  logic rsp_done;

  logic [1:0]       sel_aluop;
  logic [3:0]       sel_funct;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [OP_W-1:0]  dec_op;
  logic             dec_illegal;

  logic pend_id;
  logic pend_illegal;

`ifndef ALU_ARB_FIXED_PRIO_EN
  logic last_grant;
`endif

  // Arbitration: a lone requester always wins; a tie goes by priority policy
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
`ifdef ALU_ARB_FIXED_PRIO_EN
    gnt0 = req0_valid;
    gnt1 = req1_valid & ~req0_valid;
`else
    gnt0 = req0_valid & (~req1_valid | last_grant);
    gnt1 = req1_valid & (~req0_valid | ~last_grant);
`endif
  end

  // Payload mux for the requester being granted this cycle
  always_comb begin
    sel_aluop = load_id ? req1_aluop : req0_aluop;
    sel_funct = load_id ? req1_funct : req0_funct;
    sel_a     = load_id ? req1_a     : req0_a;
    sel_b     = load_id ? req1_b     : req0_b;
  end

  // ALUOp/Funct decode; undecodable pairs fall back to add and are flagged
  always_comb begin
    dec_op      = OP_ADD;
    dec_illegal = 1'b0;
    case (sel_aluop)
      2'b00: dec_op = OP_ADD;
      2'b01: dec_op = OP_SUB;
      2'b10: begin
        case (sel_funct)
          4'b0000: dec_op = OP_ADD;
          4'b1000: dec_op = OP_SUB;
          4'b0111: dec_op = OP_AND;
          4'b0110: dec_op = OP_OR;
          default: dec_illegal = 1'b1;
        endcase
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next state, ready strobes and datapath enables
  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    load       = 1'b0;
    load_id    = 1'b0;
    capture    = 1'b0;
    rsp_done   = 1'b0;
    case (state)
      IDLE: begin
        load_id = gnt1;
        if (rst_n && (gnt0 || gnt1)) begin
          load       = 1'b1;
          req0_ready = gnt0;
          req1_ready = gnt1;
          state_nxt  = EXEC;
        end
      end
      EXEC: begin
        capture   = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        if (rsp_valid && rsp_ready) begin
          rsp_done  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ALU input registers and in-flight bookkeeping, loaded only on a grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a         <= '0;
      alu_b         <= '0;
      alu_operation <= OP_AND;
      pend_id       <= 1'b0;
      pend_illegal  <= 1'b0;
    end else if (load) begin
      alu_a         <= sel_a;
      alu_b         <= sel_b;
      alu_operation <= dec_op;
      pend_id       <= load_id;
      pend_illegal  <= dec_illegal;
    end
  end

`ifndef ALU_ARB_FIXED_PRIO_EN
  // Round-robin history; reset to 1 so requester 0 wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    last_grant <= 1'b1;
    else if (load) last_grant <= load_id;
  end
`endif

  // Response registers: capture after the ALU settle cycle, hold until accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid   <= 1'b0;
      rsp_id      <= 1'b0;
      rsp_result  <= '0;
      rsp_zero    <= 1'b0;
      rsp_illegal <= 1'b0;
    end else if (capture) begin
      rsp_valid   <= 1'b1;
      rsp_id      <= pend_id;
      rsp_result  <= alu_result;
      rsp_zero    <= alu_zero;
      rsp_illegal <= pend_illegal;
    end else if (rsp_done) begin
      rsp_valid   <= 1'b0;
    end
  end

endmodule
